// File: rtl/ctrl_pkg.sv
// Opcodes shared with the control unit, request-kind encodings and encoder FSM states.
package ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;

    localparam logic [2:0] KIND_RTYPE   = 3'd0;
    localparam logic [2:0] KIND_ADDI    = 3'd1;
    localparam logic [2:0] KIND_ANDI    = 3'd2;
    localparam logic [2:0] KIND_ORI     = 3'd3;
    localparam logic [2:0] KIND_SW      = 3'd4;
    localparam logic [2:0] KIND_LW      = 3'd5;
    localparam logic [2:0] KIND_BEQ     = 3'd6;
    localparam logic [2:0] KIND_ILLEGAL = 3'd7;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/instr_field_pack.sv
// Combinational packing of a symbolic request into a 32-bit MIPS word; zero latency, no flow control.
module instr_field_pack
    import ctrl_pkg::*;
(
    input  logic [2:0]  kind,
    input  logic [4:0]  rs,
    input  logic [4:0]  rt,
    input  logic [4:0]  rd,
    input  logic [4:0]  shamt,
    input  logic [5:0]  funct,
    input  logic [15:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (kind)
            KIND_RTYPE: word = {OP_RTYPE, rs, rt, rd, shamt, funct};
            KIND_ADDI:  word = {OP_ADDI, rs, rt, imm};
            KIND_ANDI:  word = {OP_ANDI, rs, rt, imm};
            KIND_ORI:   word = {OP_ORI, rs, rt, imm};
            KIND_SW:    word = {OP_SW, rs, rt, imm};
            KIND_LW:    word = {OP_LW, rs, rt, imm};
            KIND_BEQ:   word = {OP_BEQ, rs, rt, imm};
            default:    illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Packs instruction requests and streams them into imem; 1-cycle latency, in_ready drops while a write stalls.
// Optional INSTR_CHECKSUM_EN adds an XOR checksum of every committed word.
module instr_encoder
    import ctrl_pkg::*;
#(
    parameter int ADDR_W    = 8,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              finish,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_kind,
    input  logic [4:0]        in_rs,
    input  logic [4:0]        in_rt,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_shamt,
    input  logic [5:0]        in_funct,
    input  logic [15:0]       in_imm,
    output logic              imem_we,
    input  logic              imem_ready,
    output logic [ADDR_W-1:0] imem_addr,
    output logic [31:0]       imem_wdata,
    output logic [ADDR_W:0]   count,
    output logic              full,
    output logic              done,
    output logic              err_illegal
`ifdef INSTR_CHECKSUM_EN
    ,
    output logic [31:0]       checksum
`endif
);

    localparam int DEPTH = 1 << ADDR_W;

    state_t            state, state_nxt;
    logic [ADDR_W:0]   ptr;
    logic [31:0]       packed_word;
    logic              illegal;
    logic              accept, commit, restart;

    instr_field_pack u_pack (
        .kind    (in_kind),
        .rs      (in_rs),
        .rt      (in_rt),
        .rd      (in_rd),
        .shamt   (in_shamt),
        .funct   (in_funct),
        .imm     (in_imm),
        .word    (packed_word),
        .illegal (illegal)
    );

    assign accept  = in_valid && in_ready;
    assign commit  = imem_we && imem_ready;
    assign restart = start && (state == IDLE || state == DONE);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start)    state_nxt = LOAD;
            LOAD:    if (finish)   state_nxt = DRAIN;
            DRAIN:   if (!imem_we) state_nxt = DONE;
            DONE:    if (start)    state_nxt = LOAD;
            default:               state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready = (state == LOAD) && !full && (!imem_we || imem_ready);
        done     = (state == DONE);
    end

    // Output register: a new word may replace the one committing this same cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            imem_we     <= 1'b0;
            imem_addr   <= ADDR_W'(BASE_ADDR);
            imem_wdata  <= '0;
            ptr         <= '0;
            count       <= '0;
            full        <= 1'b0;
            err_illegal <= 1'b0;
        end else begin
            if (commit) begin
                imem_we <= 1'b0;
                count   <= count + 1'b1;
            end
            if (restart) begin
                ptr         <= '0;
                count       <= '0;
                full        <= 1'b0;
                err_illegal <= 1'b0;
            end
            if (accept) begin
                if (illegal) begin
                    err_illegal <= 1'b1;
                end else begin
                    imem_we    <= 1'b1;
                    imem_wdata <= packed_word;
                    imem_addr  <= ADDR_W'(BASE_ADDR) + ptr[ADDR_W-1:0];
                    ptr        <= ptr + 1'b1;
                    if (ptr == (ADDR_W+1)'(DEPTH - 1)) full <= 1'b1;
                end
            end
        end
    end

`ifdef INSTR_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset)        checksum <= '0;
        else if (restart) checksum <= '0;
        else if (commit)  checksum <= checksum ^ imem_wdata;
    end
`endif

endmodule

// File: tb/tb_instr_encoder.sv
// Directed and randomized checks of instr_encoder (ADDR_W=2) against a behavioural reference model.
module tb_instr_encoder;

    localparam int AW    = 2;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start = 1'b0;
    logic          finish = 1'b0;
    logic          in_valid = 1'b0;
    logic          imem_ready = 1'b0;
    logic [2:0]    in_kind = '0;
    logic [4:0]    in_rs = '0, in_rt = '0, in_rd = '0, in_shamt = '0;
    logic [5:0]    in_funct = '0;
    logic [15:0]   in_imm = '0;
    logic          in_ready, imem_we, full, done, err_illegal;
    logic [AW-1:0] imem_addr;
    logic [31:0]   imem_wdata;
    logic [AW:0]   count;
`ifdef INSTR_CHECKSUM_EN
    logic [31:0]   checksum;
`endif

    int n_assert = 0;
    int n_fail   = 0;
    bit rnd_rdy  = 0;

    instr_encoder #(.ADDR_W(AW), .BASE_ADDR(0)) dut (
        .clk(clk), .reset(reset), .start(start), .finish(finish),
        .in_valid(in_valid), .in_ready(in_ready), .in_kind(in_kind),
        .in_rs(in_rs), .in_rt(in_rt), .in_rd(in_rd), .in_shamt(in_shamt),
        .in_funct(in_funct), .in_imm(in_imm),
        .imem_we(imem_we), .imem_ready(imem_ready), .imem_addr(imem_addr),
        .imem_wdata(imem_wdata), .count(count), .full(full), .done(done),
        .err_illegal(err_illegal)
`ifdef INSTR_CHECKSUM_EN
        , .checksum(checksum)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // MIPS field layout computed arithmetically: op<<26 | rs<<21 | rt<<16 | (rd<<11 | sh<<6 | fn) or imm.
    function automatic logic [31:0] ref_word(input int k, input int rs, input int rt,
                                              input int rd, input int sh, input int fn, input int imm);
        longint op_tab[6] = '{8, 12, 13, 43, 35, 4};
        longint w;
        if (k == 0) w = longint'(rs) * (2**21) + longint'(rt) * (2**16) + longint'(rd) * (2**11)
                        + longint'(sh) * (2**6) + longint'(fn);
        else        w = op_tab[k-1] * (longint'(1) << 26) + longint'(rs) * (2**21)
                        + longint'(rt) * (2**16) + longint'(imm);
        return w[31:0];
    endfunction

    // Reference model: 0 idle, 1 load, 2 drain, 3 done.
    int          m_st = 0, m_acc = 0, m_cnt = 0, m_addr = 0, m_nst = 0;
    bit          m_pend = 0, m_err = 0, m_rdy = 0;
    logic [31:0] m_word = '0, m_csum = '0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_st = 0; m_acc = 0; m_cnt = 0; m_pend = 0; m_err = 0; m_csum = '0;
        end else begin
            m_rdy = (m_st == 1) && (m_acc < DEPTH) && (!m_pend || imem_ready);
            m_nst = m_st;
            if ((m_st == 0 || m_st == 3) && start) begin
                m_nst = 1; m_acc = 0; m_cnt = 0; m_err = 0; m_csum = '0;
            end else if (m_st == 1 && finish) m_nst = 2;
            else if (m_st == 2 && !m_pend) m_nst = 3;
            if (m_pend && imem_ready) begin
                m_cnt++; m_csum ^= m_word; m_pend = 0;
            end
            if (in_valid && m_rdy) begin
                if (in_kind == 3'd7) m_err = 1;
                else begin
                    m_pend = 1;
                    m_word = ref_word(int'(in_kind), int'(in_rs), int'(in_rt), int'(in_rd),
                                      int'(in_shamt), int'(in_funct), int'(in_imm));
                    m_addr = m_acc;
                    m_acc++;
                end
            end
            m_st = m_nst;
        end
    end

    always @(negedge clk) begin
        chk("in_ready", in_ready, (m_st == 1) && (m_acc < DEPTH) && (!m_pend || imem_ready));
        chk("imem_we", imem_we, m_pend);
        chk("count", count, m_cnt);
        chk("full", full, m_acc == DEPTH);
        chk("done", done, m_st == 3);
        chk("err_illegal", err_illegal, m_err);
        if (m_pend) begin
            chk("imem_addr", imem_addr, m_addr);
            chk("imem_wdata", imem_wdata, m_word);
        end
`ifdef INSTR_CHECKSUM_EN
        chk("checksum", checksum, m_csum);
`endif
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rnd_rdy) imem_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic pulse_start();
        start = 1'b1; tick(); start = 1'b0;
    endtask

    task automatic pulse_finish();
        finish = 1'b1; tick(); finish = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        for (int i = 0; i < bound && !done; i++) tick();
        chk("wait_done", done, 1'b1);
    endtask

    task automatic offer(input logic [2:0] k, input logic [4:0] rs, input logic [4:0] rt,
                         input logic [4:0] rd, input logic [4:0] sh, input logic [5:0] fn,
                         input logic [15:0] imm, input int max_wait, input bit fin, output bit took);
        in_valid = 1'b1; in_kind = k; in_rs = rs; in_rt = rt; in_rd = rd;
        in_shamt = sh; in_funct = fn; in_imm = imm;
        took = 0;
        for (int i = 0; i < max_wait && !took; i++) begin
            @(negedge clk);
            took = in_ready;
            #1;
            if (took && fin) finish = 1'b1;
            tick();
            finish = 1'b0;
        end
        in_valid = 1'b0;
    endtask

    initial begin
        bit took;
        int n;
        bit finished;
        #600000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit took, finished;
        int n, nreq;
        logic [2:0] k;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_we", imem_we, 1'b0);
        chk("rst_addr", imem_addr, 0);
        chk("rst_wdata", imem_wdata, 0);
        chk("rst_count", count, 0);
        chk("rst_full", full, 1'b0);
        chk("rst_done", done, 1'b0);
        chk("rst_err", err_illegal, 1'b0);
        chk("rst_in_ready", in_ready, 1'b0);
        reset = 1'b0;

        // IDLE ignores requests and finish
        in_valid = 1'b1; in_kind = 3'd1;
        pulse_finish();
        repeat (2) tick();
        chk("idle_in_ready", in_ready, 1'b0);
        chk("idle_done", done, 1'b0);
        in_valid = 1'b0;

        // single addi
        pulse_start();
        imem_ready = 1'b1;
        offer(3'd1, 5'd9, 5'd8, 5'd0, 5'd0, 6'd0, 16'h0005, 4, 0, took);
        chk("addi_took", took, 1'b1);
        chk("addi_we", imem_we, 1'b1);
        chk("addi_addr", imem_addr, 0);
        chk("addi_wdata", imem_wdata, 32'h21280005);
        tick();
        chk("addi_count", count, 1);
        pulse_finish();
        wait_done(10);

        // back-to-back R-type and lw, then stalled beq
        pulse_start();
        offer(3'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'h0, 4, 0, took);
        chk("r_wdata", imem_wdata, 32'h00221820);
        chk("r_addr", imem_addr, 0);
        offer(3'd5, 5'd29, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0008, 1, 0, took);
        chk("lw_took", took, 1'b1);
        chk("lw_wdata", imem_wdata, 32'h8FA40008);
        chk("lw_addr", imem_addr, 1);
        chk("lw_count", count, 1);
        offer(3'd6, 5'd1, 5'd0, 5'd0, 5'd0, 6'd0, 16'hFFFF, 4, 0, took);
        imem_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 1'b0);
            chk("stall_we", imem_we, 1'b1);
            chk("stall_wdata", imem_wdata, 32'h1020FFFF);
            tick();
        end
        chk("stall_count", count, 2);
        imem_ready = 1'b1;
        tick();
        chk("beq_count", count, 3);
        chk("beq_we", imem_we, 1'b0);
        pulse_start();
        chk("load_start_ignored", count, 3);
        pulse_finish();
        wait_done(10);

        // fill all DEPTH words, fifth request refused
        pulse_start();
        n = 0;
        for (int i = 0; i < 5; i++) begin
            offer(3'd1, 5'd1, 5'd2, 5'd0, 5'd0, 6'd0, 16'(i), 3, 0, took);
            n += int'(took);
            if (i == 3) chk("full_after_4", full, 1'b1);
        end
        chk("full_accepts", n, 4);
        chk("full_in_ready", in_ready, 1'b0);
        pulse_finish();
        wait_done(10);
        chk("full_count", count, 4);

        // illegal kind between two addi
        pulse_start();
        offer(3'd1, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0001, 4, 0, took);
        offer(3'd7, 5'd5, 5'd6, 5'd7, 5'd1, 6'd2, 16'h0003, 4, 0, took);
        chk("ill_took", took, 1'b1);
        chk("ill_err", err_illegal, 1'b1);
        chk("ill_we", imem_we, 1'b0);
        offer(3'd1, 5'd3, 5'd4, 5'd0, 5'd0, 6'd0, 16'h0002, 4, 0, took);
        chk("ill_addr2", imem_addr, 1);
        pulse_finish();
        wait_done(10);
        chk("ill_count", count, 2);
        pulse_start();
        chk("ill_cleared", err_illegal, 1'b0);
        pulse_finish();
        wait_done(10);

        // randomized sessions with random memory back-pressure
        rnd_rdy = 1;
        for (int s = 0; s < 25; s++) begin
            pulse_start();
            nreq = $urandom_range(1, 6);
            finished = 0;
            for (int r = 0; r < nreq; r++) begin
                k = ($urandom_range(0, 9) == 0) ? 3'd7 : 3'($urandom_range(0, 6));
                offer(k, 5'($urandom), 5'($urandom), 5'($urandom), 5'($urandom), 6'($urandom),
                      16'($urandom), 20, (r == nreq - 1) && ($urandom_range(0, 1) == 1), took);
                if (finish === 1'b0 && took && r == nreq - 1 && m_st == 2) finished = 1;
                repeat ($urandom_range(0, 2)) tick();
            end
            if (!finished && m_st == 1) pulse_finish();
            wait_done(80);
        end
        rnd_rdy = 0;

        // reset while a write is stalled
        pulse_start();
        imem_ready = 1'b1;
        offer(3'd3, 5'd7, 5'd8, 5'd0, 5'd0, 6'd0, 16'hABCD, 4, 0, took);
        offer(3'd2, 5'd1, 5'd1, 5'd0, 5'd0, 6'd0, 16'h1234, 4, 0, took);
        imem_ready = 1'b0;
        tick();
        chk("pre_rst_count", count, 1);
`ifdef INSTR_CHECKSUM_EN
        chk("pre_rst_csum", checksum, ref_word(3, 7, 8, 0, 0, 0, 16'hABCD));
`endif
        #2 reset = 1'b1;
        #1;
        chk("arst_we", imem_we, 1'b0);
        chk("arst_count", count, 0);
        chk("arst_in_ready", in_ready, 1'b0);
        chk("arst_done", done, 1'b0);
`ifdef INSTR_CHECKSUM_EN
        chk("arst_csum", checksum, 0);
`endif
        tick();
        reset = 1'b0;
        repeat (2) tick();
        chk("post_rst_idle", in_ready, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
